// File: rtl/alu_mc_pkg.sv
// Shared types and helpers for the multi-cycle ALU: opcodes, FSM states, op classification.
package alu_mc_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10,
    OP_MULH = 4'd11,
    OP_DIV  = 4'd12,
    OP_REM  = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_e;

  function automatic logic is_iterative(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_divide(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide, one bit per clock.
// Result is {high, low} = {product hi, product lo} or {remainder, quotient}.
module alu_mc_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      mode_i,
  input  logic [DATA_WIDTH-1:0]     a_i,
  input  logic [DATA_WIDTH-1:0]     b_i,
  output logic                      done_c,
  output logic [2*DATA_WIDTH-1:0]   acc_next_c
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic [2*W-1:0]   acc_q;
  logic [W-1:0]     opb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             mode_q;

  logic [W-1:0]     mul_addend_c;
  logic [W:0]       mul_sum_c;
  logic [W:0]       div_rem_c;
  logic [W:0]       div_diff_c;
  logic             div_ge_c;
  logic [2*W-1:0]   acc_step_c;

  // Multiplier sits in the low half and shifts out LSB-first while partial sums enter the top.
  assign mul_addend_c = acc_q[0] ? opb_q : W'(0);
  assign mul_sum_c    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_addend_c};

  // Partial remainder gains the next dividend bit; a zero divisor always "fits", giving all-ones.
  assign div_rem_c  = acc_q[2*W-1:W-1];
  assign div_ge_c   = div_rem_c >= {1'b0, opb_q};
  assign div_diff_c = div_rem_c - {1'b0, opb_q};

  always_comb begin
    acc_step_c = {mul_sum_c, acc_q[W-1:1]};
    if (mode_q) begin
      if (div_ge_c) acc_step_c = {div_diff_c[W-1:0], acc_q[W-2:0], 1'b1};
      else          acc_step_c = {acc_q[2*W-2:0], 1'b0};
    end
  end

  assign done_c     = busy_q && (cnt_q == CNT_W'(0));
  assign acc_next_c = acc_step_c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      mode_q <= 1'b0;
    end else if (start_i) begin
      acc_q  <= {W'(0), a_i};
      opb_q  <= b_i;
      mode_q <= mode_i;
      cnt_q  <= CNT_W'(W - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_step_c;
      if (cnt_q == CNT_W'(0)) busy_q <= 1'b0;
      else                    cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: valid/ready handshake, IDLE/MUL/DIV control and single-cycle datapath.
// Iterative ops are delegated to alu_mc_iter; all outputs are registered.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [3:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned SH_W = $clog2(DATA_WIDTH);

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  logic           accept_c;
  logic           iter_start_c;
  logic           iter_mode_c;
  logic           iter_done_c;
  logic [2*W-1:0] iter_acc_c;
  logic [W-1:0]   iter_res_c;
  logic [W-1:0]   single_c;
  logic [SH_W-1:0] shamt_c;

  assign accept_c    = i_valid && ready_q;
  assign iter_mode_c = is_divide(i_op);
  assign shamt_c     = i_data1[SH_W-1:0];

  alu_mc_iter #(.DATA_WIDTH(W)) u_iter (
    .clk_i      (i_clock),
    .rst_i      (i_reset),
    .start_i    (iter_start_c),
    .mode_i     (iter_mode_c),
    .a_i        (i_data0),
    .b_i        (i_data1),
    .done_c     (iter_done_c),
    .acc_next_c (iter_acc_c)
  );

  // Single-cycle datapath; iterative and undefined opcodes yield 0 here.
  always_comb begin
    single_c = '0;
    case (op_e'(i_op))
      OP_ADD:  single_c = i_data0 + i_data1;
      OP_SUB:  single_c = i_data0 - i_data1;
      OP_AND:  single_c = i_data0 & i_data1;
      OP_OR:   single_c = i_data0 | i_data1;
      OP_XOR:  single_c = i_data0 ^ i_data1;
      OP_SLL:  single_c = i_data0 << shamt_c;
      OP_SRL:  single_c = i_data0 >> shamt_c;
      OP_SRA:  single_c = W'($signed(i_data0) >>> shamt_c);
      OP_SLT:  single_c = W'($signed(i_data0) < $signed(i_data1));
      OP_SLTU: single_c = W'(i_data0 < i_data1);
      default: single_c = '0;
    endcase
  end

  // High half carries MULH product bits or the REM remainder.
  always_comb begin
    iter_res_c = iter_acc_c[W-1:0];
    if ((op_q == OP_MULH) || (op_q == OP_REM)) iter_res_c = iter_acc_c[2*W-1:W];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c && is_iterative(i_op)) state_d = is_divide(i_op) ? ST_DIV : ST_MUL;
      end
      ST_MUL, ST_DIV: begin
        if (iter_done_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_d      = (state_d == ST_IDLE);
    valid_d      = 1'b0;
    data_d       = data_q;
    op_d         = op_q;
    iter_start_c = 1'b0;
    if (accept_c) begin
      op_d = op_e'(i_op);
      if (is_iterative(i_op)) begin
        iter_start_c = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = single_c;
      end
    end
    if ((state_q != ST_IDLE) && iter_done_c) begin
      valid_d = 1'b1;
      data_d  = iter_res_c;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (DATA_WIDTH=32): directed scenarios plus randomized ops
// against a plain-arithmetic reference model.
module tb_alu_mc;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [3:0]   i_op;
  logic [W-1:0] i_data0;
  logic [W-1:0] i_data1;
  logic         o_valid;
  logic [W-1:0] o_data;

  int checks = 0;
  int errors = 0;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_data0 (i_data0),
    .i_data1 (i_data1),
    .o_valid (o_valid),
    .o_data  (o_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    int unsigned sh;
    sh   = b % 32;
    prod = 64'(a) * 64'(b);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return 32'($signed(a) >>> sh);
      8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return prod[31:0];
      11: return prod[63:32];
      12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_iter(input int op);
    return (op >= 10) && (op <= 13);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_op = 4'd0; i_data0 = '0; i_data1 = '0;
    step(); step();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h, want ready=1 valid=0 data=0", o_ready, o_valid, o_data);
    end
    rst = 1'b0;
    step();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b valid=%b, want ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  task automatic test_back_to_back();
    i_valid = 1'b1; i_op = 4'd0; i_data0 = 32'd5; i_data1 = 32'd7;
    step();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'd12 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_add: valid=%b data=%h ready=%b, want valid=1 data=0000000c ready=1", o_valid, o_data, o_ready);
    end
    i_op = 4'd4; i_data0 = 32'hF0F0_F0F0; i_data1 = 32'hFFFF_0000;
    step();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'h0F0F_F0F0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_xor: valid=%b data=%h ready=%b, want valid=1 data=0f0ff0f0 ready=1", o_valid, o_data, o_ready);
    end
    i_valid = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b0 || o_data !== 32'h0F0F_F0F0) begin
      errors++;
      $display("FAIL b2b_pulse_end: valid=%b data=%h, want valid=0 data=0f0ff0f0", o_valid, o_data);
    end
  endtask

  task automatic test_iterative();
    int          ops [6] = '{10, 11, 12, 13, 12, 13};
    logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h1234, 32'h1234};
    logic [31:0] bs  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] exp [6] = '{32'h1, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234};
    for (int i = 0; i < 6; i++) begin
      int lat;
      int rdy_low;
      lat = 0; rdy_low = 0;
      i_valid = 1'b1; i_op = 4'(ops[i]); i_data0 = as[i]; i_data1 = bs[i];
      step();
      i_valid = 1'b0; i_data0 = $urandom; i_data1 = $urandom;
      while (!o_valid && lat < 40) begin
        if (!o_ready) rdy_low++;
        step();
        lat++;
      end
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp[i] || lat != 32 || rdy_low != 32 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL iter_op%0d_case%0d: data=%h lat=%0d rdy_low=%0d ready=%b, want data=%h lat=32 rdy_low=32 ready=1",
                 ops[i], i, o_data, lat, rdy_low, o_ready, exp[i]);
      end
      step();
      checks++;
      if (o_valid !== 1'b0 || o_data !== exp[i]) begin
        errors++;
        $display("FAIL iter_hold_case%0d: valid=%b data=%h, want valid=0 data=%h", i, o_valid, o_data, exp[i]);
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    int lat;
    int extra;
    lat = 0; extra = 0;
    i_valid = 1'b1; i_op = 4'd12; i_data0 = 32'd100; i_data1 = 32'd7;
    step();
    i_op = 4'd0; i_data0 = 32'd11; i_data1 = 32'd22;
    while (!o_valid && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'd14 || lat != 32) begin
      errors++;
      $display("FAIL busy_div_result: data=%h lat=%0d, want data=0000000e lat=32", o_data, lat);
    end
    step();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'd33) begin
      errors++;
      $display("FAIL busy_held_add: valid=%b data=%h, want valid=1 data=00000021", o_valid, o_data);
    end
    i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (o_valid) extra++;
    end
    checks++;
    if (extra != 0 || o_data !== 32'd33) begin
      errors++;
      $display("FAIL busy_no_extra_valid: extra=%0d data=%h, want extra=0 data=00000021", extra, o_data);
    end
  endtask

  task automatic test_reset_mid_op();
    int spurious;
    spurious = 0;
    i_valid = 1'b1; i_op = 4'd10; i_data0 = 32'h0001_2345; i_data1 = 32'h0000_0ABC;
    step();
    i_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_op: valid=%b ready=%b data=%h, want valid=0 ready=1 data=0", o_valid, o_ready, o_data);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_valid) spurious++;
    end
    checks++;
    if (spurious != 0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort_no_valid: spurious=%0d ready=%b, want spurious=0 ready=1", spurious, o_ready);
    end
    i_valid = 1'b1; i_op = 4'd1; i_data0 = 32'd3; i_data1 = 32'd5;
    step();
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL reset_then_sub: valid=%b data=%h, want valid=1 data=fffffffe", o_valid, o_data);
    end
  endtask

  task automatic test_shift_compare();
    int          ops [6] = '{7, 8, 9, 15, 5, 6};
    logic [31:0] as  [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'h21, 32'h1, 32'h1, 32'h9, 32'h1F, 32'h3F};
    logic [31:0] exp [6] = '{32'hC000_0000, 32'h1, 32'h0, 32'h0, 32'h8000_0000, 32'h1};
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1; i_op = 4'(ops[i]); i_data0 = as[i]; i_data1 = bs[i];
      step();
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp[i] || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL shcmp_op%0d: valid=%b data=%h ready=%b, want valid=1 data=%h ready=1",
                 ops[i], o_valid, o_data, o_ready, exp[i]);
      end
    end
    i_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int          op;
      int          lat;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      op = int'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      exp = ref_model(op, a, b);
      lat = 0;
      i_valid = 1'b1; i_op = 4'(op); i_data0 = a; i_data1 = b;
      step();
      i_valid = 1'b0; i_data0 = $urandom; i_data1 = $urandom;
      while (!o_valid && lat < 40) begin
        step();
        lat++;
      end
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp || lat != (is_iter(op) ? 32 : 0)) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: data=%h extra_edges=%0d, want data=%h extra_edges=%0d",
                 n, op, a, b, o_data, lat, exp, is_iter(op) ? 32 : 0);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_iterative();
    test_ignore_while_busy();
    test_reset_mid_op();
    test_shift_compare();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
